// File: rtl/cfu_pkg.sv
// CFU-LI shared definitions: status encoding and parameter legality check.
package cfu_pkg;

  localparam int CFU_STATUS_W = 3;

  typedef enum logic [CFU_STATUS_W-1:0] {
    CFU_OK = 3'd0
  } cfu_status_e;

  // True when the data width and response latency are ones this CFU supports.
  function automatic bit cfu_params_legal(input int data_w, input int latency);
    return ((data_w == 32) || (data_w == 64)) && (latency >= 0) && (latency <= 2);
  endfunction

endpackage

// File: rtl/common_pkg.sv
// Small helpers shared across blocks of this codebase.
package common_pkg;

  // Larger of two integers; widens zero-width id ports to a single bit.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count built as a recursive binary adder tree.
module popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]       data,
  output logic [$clog2(W):0] count
);

  localparam int CW = $clog2(W) + 1;

  if (W == 1) begin : g_leaf
    assign count = data;
  end else begin : g_split
    localparam int LW = W / 2;
    localparam int HW = W - LW;

    logic [$clog2(LW):0] lo_cnt;
    logic [$clog2(HW):0] hi_cnt;

    popcount #(.W(LW)) u_lo (.data(data[LW-1:0]), .count(lo_cnt));
    popcount #(.W(HW)) u_hi (.data(data[W-1:LW]), .count(hi_cnt));

    assign count = CW'(lo_cnt) + CW'(hi_cnt);
  end

endmodule

// File: rtl/popcount_cfu.sv
// CFU-LI custom function unit returning the popcount of operand 0, with
// a selectable response latency of 0, 1 or 2 enabled cycles.
module popcount_cfu
  import cfu_pkg::*;
  import common_pkg::*;
#(
  parameter int CFU_LI_VERSION = 'h01000,
  parameter int CFU_N_CFUS     = 1,
  parameter int CFU_CFU_ID_W   = 0,
  parameter int CFU_FUNC_ID_W  = 0,
  parameter int CFU_DATA_W     = 32,
  parameter int CFU_LATENCY    = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clk_en,
  input  logic                                req_valid,
  input  logic [max_int(CFU_CFU_ID_W,1)-1:0]  req_cfu,
  input  logic [max_int(CFU_FUNC_ID_W,1)-1:0] req_func,
  input  logic [CFU_DATA_W-1:0]               req_data0,
  input  logic [CFU_DATA_W-1:0]               req_data1,
  output logic                                resp_valid,
  output logic [CFU_STATUS_W-1:0]             resp_status,
  output logic [CFU_DATA_W-1:0]               resp_data
);

  localparam int DW = CFU_DATA_W;
  localparam int CW = $clog2(DW) + 1;
  localparam int NB = DW / 8;

  // Only one function exists, so the id and second operand never matter.
  logic unused_ok;
  assign unused_ok = ^{clk, rst, clk_en, req_cfu, req_func, req_data1,
                       CFU_LI_VERSION[0], CFU_N_CFUS[0]};

  assign resp_status = CFU_OK;

  if (!cfu_params_legal(CFU_DATA_W, CFU_LATENCY)) begin : g_bad_params
    $error("popcount_cfu: CFU_DATA_W must be 32 or 64 and CFU_LATENCY 0..2");
  end

  if (CFU_LATENCY == 0) begin : g_lat0
    logic [CW-1:0] word_cnt;

    popcount #(.W(DW)) u_word (.data(req_data0), .count(word_cnt));

    assign resp_valid = req_valid;
    assign resp_data  = DW'(word_cnt);

  end else if (CFU_LATENCY == 1) begin : g_lat1
    logic [CW-1:0] word_cnt;
    logic          v_q;
    logic [DW-1:0] d_q;

    popcount #(.W(DW)) u_word (.data(req_data0), .count(word_cnt));

    // Single result register; reset wins over clk_en, otherwise hold when disabled.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
        v_q <= 1'b0;
        // NOTE: data registers are reset too (not just valid) so resp_data is
        // never X after reset, even though it is don't-care while invalid.
        d_q <= '0;
      end else if (clk_en) begin
        v_q <= req_valid;
        d_q <= DW'(word_cnt);
      end
    end

    assign resp_valid = v_q;
    assign resp_data  = d_q;

  end else begin : g_lat2
    logic [3:0]    byte_cnt [NB];
    logic [3:0]    s1_cnt   [NB];
    logic          s1_v;
    logic [CW-1:0] word_sum;
    logic          s2_v;
    logic [DW-1:0] s2_d;

    for (genvar b = 0; b < NB; b++) begin : g_byte
      popcount #(.W(8)) u_byte (.data(req_data0[8*b +: 8]), .count(byte_cnt[b]));
    end

    // Stage 1: capture per-byte partial counts.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v <= 1'b0;
        for (int b = 0; b < NB; b++) s1_cnt[b] <= '0;
      end else if (clk_en) begin
        s1_v <= req_valid;
        for (int b = 0; b < NB; b++) s1_cnt[b] <= byte_cnt[b];
      end
    end

    // Stage 2 combinational sum of the byte partials.
    always_comb begin
      // NOTE: default assignment first so no path leaves word_sum unassigned
      // (which would infer a latch).
      word_sum = '0;
      for (int b = 0; b < NB; b++) word_sum = word_sum + CW'(s1_cnt[b]);
    end

    // Stage 2: register the final word count.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v <= 1'b0;
        s2_d <= '0;
      end else if (clk_en) begin
        s2_v <= s1_v;
        s2_d <= DW'(word_sum);
      end
    end

    assign resp_valid = s2_v;
    assign resp_data  = s2_d;
  end

endmodule

// File: tb/tb_popcount_cfu.sv
// Self-checking bench for popcount_cfu across latencies 0/1/2 and widths 32/64.
module tb_popcount_cfu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clk_en, req_valid;
  logic [0:0]  req_cfu, req_func;
  logic [31:0] req_data0, req_data1;
  logic [63:0] req_data0_w, req_data1_w;

  logic        l0_valid, l0w_valid, l1_valid, l2_valid;
  logic [2:0]  l0_status, l0w_status, l1_status, l2_status;
  logic [31:0] l0_data, l1_data, l2_data;
  logic [63:0] l0w_data;

  popcount_cfu #(.CFU_DATA_W(32), .CFU_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid),
    .req_cfu(req_cfu), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(l0_valid), .resp_status(l0_status), .resp_data(l0_data));

  popcount_cfu #(.CFU_DATA_W(64), .CFU_LATENCY(0)) u_l0w (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid),
    .req_cfu(req_cfu), .req_func(req_func), .req_data0(req_data0_w), .req_data1(req_data1_w),
    .resp_valid(l0w_valid), .resp_status(l0w_status), .resp_data(l0w_data));

  popcount_cfu #(.CFU_DATA_W(32), .CFU_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid),
    .req_cfu(req_cfu), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(l1_valid), .resp_status(l1_status), .resp_data(l1_data));

  popcount_cfu #(.CFU_DATA_W(32), .CFU_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid),
    .req_cfu(req_cfu), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(l2_valid), .resp_status(l2_status), .resp_data(l2_data));

  int tests = 0;
  int fails = 0;

  // Reference history: one entry per enabled edge, newest first.
  // A latency-N unit shows entry N-1 after each edge.
  typedef struct {
    bit          v;
    int unsigned cnt;
    bit          zeroed;
  } rec_t;
  rec_t hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    check("l0_valid",   64'(l0_valid),   64'(req_valid));
    check("l0_data",    64'(l0_data),    64'($countones(req_data0)));
    check("l0_status",  64'(l0_status),  64'd0);
    check("l0w_valid",  64'(l0w_valid),  64'(req_valid));
    check("l0w_data",   l0w_data,        64'($countones(req_data0_w)));
    check("l0w_status", 64'(l0w_status), 64'd0);
  endtask

  task automatic check_pipe();
    check("l1_valid",  64'(l1_valid),  64'(hist[0].v));
    if (hist[0].v || hist[0].zeroed) check("l1_data", 64'(l1_data), 64'(hist[0].cnt));
    check("l1_status", 64'(l1_status), 64'd0);
    check("l2_valid",  64'(l2_valid),  64'(hist[1].v));
    if (hist[1].v || hist[1].zeroed) check("l2_data", 64'(l2_data), 64'(hist[1].cnt));
    check("l2_status", 64'(l2_status), 64'd0);
  endtask

  // One clock: update the reference at the edge, compare at the falling edge.
  task automatic tick();
    rec_t r;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      r = '{v: 1'b0, cnt: 0, zeroed: 1'b1};
      hist.push_back(r);
      hist.push_back(r);
    end else if (clk_en) begin
      r = '{v: req_valid, cnt: $countones(req_data0), zeroed: 1'b0};
      hist.push_front(r);
      void'(hist.pop_back());
    end
    @(negedge clk);
    check_pipe();
    check_comb();
  endtask

  initial begin
    rec_t z;
    z = '{v: 1'b0, cnt: 0, zeroed: 1'b0};
    hist.push_back(z);
    hist.push_back(z);

    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0;
    req_cfu = 1'b0; req_func = 1'b0;
    req_data0 = 32'h0; req_data1 = 32'h0;
    req_data0_w = 64'h0; req_data1_w = 64'h0;

    // Reset with clk_en low still clears everything.
    @(negedge clk);
    clk_en = 1'b0;
    tick();
    check("rst_l1_valid", 64'(l1_valid), 64'd0);
    check("rst_l2_data",  64'(l2_data),  64'd0);
    clk_en = 1'b1;

    // Combinational corner cases.
    req_valid = 1'b1;
    req_data0 = 32'h0000_0000;
    req_data0_w = 64'h8000_0000_0000_0001;
    #1;
    check("zero_w32",   64'(l0_data),   64'd0);
    check("zero_st",    64'(l0_status), 64'd0);
    check("ends_w64",   l0w_data,       64'd2);
    req_data0 = 32'hFFFF_FFFF; req_data1 = 32'h1234_5678;
    req_data0_w = 64'hFFFF_FFFF_FFFF_FFFF; req_data1_w = 64'h1234_5678_9ABC_DEF0;
    req_func = 1'b1; req_cfu = 1'b1;
    #1;
    check("ones_w32",   64'(l0_data),   64'd32);
    check("ones_w64",   l0w_data,       64'd64);
    check("ones_valid", 64'(l0_valid),  64'd1);
    req_func = 1'b0; req_cfu = 1'b0; req_data1 = 32'h0;

    // Back-to-back requests through the 2-stage pipeline.
    rst = 1'b0;
    req_valid = 1'b1; req_data0 = 32'hF0F0_F0F0;
    tick();
    check("b2b_l2_idle", 64'(l2_valid), 64'd0);
    req_data0 = 32'h0000_0001;
    tick();
    check("b2b_l2_v0", 64'(l2_valid), 64'd1);
    check("b2b_l2_d0", 64'(l2_data),  64'd16);
    req_data0 = 32'h7FFF_FFFF;
    tick();
    check("b2b_l2_d1", 64'(l2_data),  64'd1);
    req_valid = 1'b0;
    tick();
    check("b2b_l2_d2", 64'(l2_data),  64'd31);
    tick();
    check("b2b_l2_end", 64'(l2_valid), 64'd0);

    // Reset while requests are in flight discards them.
    req_valid = 1'b1; req_data0 = 32'h0000_00FF;
    tick();
    req_data0 = 32'h0F0F_0000; rst = 1'b1;
    tick();
    check("mid_rst_l1_v", 64'(l1_valid), 64'd0);
    check("mid_rst_l1_d", 64'(l1_data),  64'd0);
    check("mid_rst_l2_v", 64'(l2_valid), 64'd0);
    check("mid_rst_l2_d", 64'(l2_data),  64'd0);
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_late_l1", 64'(l1_valid), 64'd0);
      check("no_late_l2", 64'(l2_valid), 64'd0);
    end

    // Stall with data in flight: outputs freeze, then drain in order.
    req_valid = 1'b1; req_data0 = 32'hAAAA_AAAA;
    tick();
    req_data0 = 32'h0000_00FF;
    tick();
    clk_en = 1'b0; req_data0 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_l2_v", 64'(l2_valid), 64'd1);
      check("stall_l2_d", 64'(l2_data),  64'd16);
      check("stall_l1_d", 64'(l1_data),  64'd8);
    end
    clk_en = 1'b1; req_valid = 1'b0;
    tick();
    check("resume_l2_d", 64'(l2_data),  64'd8);
    tick();
    check("resume_l2_v", 64'(l2_valid), 64'd0);

    // Random traffic with random enables and occasional resets.
    for (int i = 0; i < 300; i++) begin
      req_valid   = 1'($urandom_range(0, 1));
      clk_en      = ($urandom_range(0, 9) < 8);
      rst         = ($urandom_range(0, 39) == 0);
      req_cfu     = 1'($urandom);
      req_func    = 1'($urandom);
      req_data0   = $urandom;
      req_data1   = $urandom;
      req_data0_w = {$urandom, $urandom};
      req_data1_w = {$urandom, $urandom};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
